// File: rtl/result_bcd_display.sv
// ---------------------------------------------------------------------------
// result_bcd_display
//
// Shows the box-nesting solver's binary answer in decimal on six
// seven-segment displays. A sequential double-dabble (shift-and-add-3)
// converts one input bit per cycle. A new conversion starts whenever the
// input differs from the value currently shown. The block also blanks leading
// zeros and shows dashes on overflow.
//
// Parameters
//   IN_W      width of the binary input (4..32)
//   BLANK_LZ  1 = blank leading zero digits, 0 = always show six digits
//
// Ports
//   clk              system clock
//   rst              synchronous, active-high reset
//   value[IN_W-1:0]  binary result from the solver
//   hled0..hled5     active-low segments (bit0=a .. bit6=g); hled0 = ones
//   busy             high while a conversion is in progress
//   updated          one-cycle pulse when the display registers change
//   ovf              high while the displayed value exceeds 999999
// ---------------------------------------------------------------------------
module result_bcd_display #(
  parameter int IN_W     = 24,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] value,
  output logic [6:0]      hled0,
  output logic [6:0]      hled1,
  output logic [6:0]      hled2,
  output logic [6:0]      hled3,
  output logic [6:0]      hled4,
  output logic [6:0]      hled5,
  output logic            busy,
  output logic            updated,
  output logic            ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_LATCH
  } state_e;

  localparam int                CNT_W      = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(IN_W - 1);
  localparam logic [6:0]        SEG_BLANK  = 7'b1111111;
  localparam logic [6:0]        SEG_DASH   = 7'b0111111;
  localparam logic [6:0]        SEG_ZERO   = 7'b1000000;

  // Active-low segment pattern for one BCD digit. Codes above 9 cannot come
  // out of a valid conversion, so they map to a dash.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1011000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_DASH;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [IN_W-1:0]   last_value_q, last_value_d;
  logic [IN_W-1:0]   cap_value_q, cap_value_d;
  logic              cap_ovf_q, cap_ovf_d;
  logic [IN_W-1:0]   shift_q, shift_d;
  logic [23:0]       bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        hled_q [6];
  logic [6:0]        hled_d [6];
  logic              busy_q, busy_d;
  logic              updated_q, updated_d;
  logic              ovf_q, ovf_d;

  // FSM control strobes
  logic              capture_en;
  logic              shift_en;
  logic              latch_en;

  // Helper terms
  logic              value_changed;
  logic              last_shift;
  logic [32:0]       value_wide;
  logic [23:0]       bcd_adj;
  logic [6:0]        seg_new [6];
  logic              leading_zero;

  assign value_changed = (value != last_value_q);
  assign last_shift    = (cnt_q == LAST_SHIFT);
  // Widened so the 999999 comparison works for every IN_W. For IN_W < 20
  // the compare is constant false.
  assign value_wide    = 33'(value);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values present before the edge, whatever the block order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: each combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (value_changed) state_d = S_CONVERT;
      S_CONVERT: if (last_shift)    state_d = S_LATCH;
      S_LATCH:                      state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output decode
  // -------------------------------------------------------------------------
  always_comb begin
    capture_en = 1'b0;
    shift_en   = 1'b0;
    latch_en   = 1'b0;
    case (state_q)
      S_IDLE:    capture_en = value_changed;
      S_CONVERT: shift_en   = 1'b1;
      S_LATCH:   latch_en   = 1'b1;
      default:   ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Double-dabble correction: each nibble >= 5 gets +3 before the shift, so
  // it carries correctly into the next decade when doubled.
  // -------------------------------------------------------------------------
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // -------------------------------------------------------------------------
  // Display patterns from the finished BCD value. Scan from the top digit
  // down. A digit is blank while every digit above it (and itself) is zero.
  // The ones digit is always shown, so zero still appears as "0".
  // -------------------------------------------------------------------------
  always_comb begin
    leading_zero = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      if (cap_ovf_q)
        seg_new[i] = SEG_DASH;
      else if (BLANK_LZ && (i != 0) && leading_zero && (bcd_q[4*i +: 4] == 4'd0))
        seg_new[i] = SEG_BLANK;
      else
        seg_new[i] = seg7(bcd_q[4*i +: 4]);
      if (bcd_q[4*i +: 4] != 4'd0) leading_zero = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    last_value_d = last_value_q;
    cap_value_d  = cap_value_q;
    cap_ovf_d    = cap_ovf_q;
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    hled_d       = hled_q;
    busy_d       = busy_q;
    updated_d    = 1'b0;
    ovf_d        = ovf_q;

    if (capture_en) begin
      shift_d     = value;
      cap_value_d = value;
      cap_ovf_d   = (value_wide > 33'd999999);
      bcd_d       = '0;
      cnt_d       = '0;
      busy_d      = 1'b1;
    end

    if (shift_en) begin
      // The BCD bit shifted out above bit 23 is dropped. Values that large
      // are flagged by cap_ovf and shown as dashes.
      bcd_d   = {bcd_adj[22:0], shift_q[IN_W-1]};
      shift_d = {shift_q[IN_W-2:0], 1'b0};
      cnt_d   = cnt_q + CNT_W'(1);
    end

    if (latch_en) begin
      hled_d       = seg_new;
      last_value_d = cap_value_q;
      ovf_d        = cap_ovf_q;
      updated_d    = 1'b1;
      busy_d       = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // NOTE: every register here is reset, including the working shift and BCD
  // registers. A reset mid-conversion then leaves no stale partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_value_q <= '0;
      cap_value_q  <= '0;
      cap_ovf_q    <= 1'b0;
      shift_q      <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      hled_q[0]    <= SEG_ZERO;
      for (int i = 1; i < 6; i++) hled_q[i] <= SEG_BLANK;
      busy_q       <= 1'b0;
      updated_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      last_value_q <= last_value_d;
      cap_value_q  <= cap_value_d;
      cap_ovf_q    <= cap_ovf_d;
      shift_q      <= shift_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      hled_q       <= hled_d;
      busy_q       <= busy_d;
      updated_q    <= updated_d;
      ovf_q        <= ovf_d;
    end
  end

  assign hled0   = hled_q[0];
  assign hled1   = hled_q[1];
  assign hled2   = hled_q[2];
  assign hled3   = hled_q[3];
  assign hled4   = hled_q[4];
  assign hled5   = hled_q[5];
  assign busy    = busy_q;
  assign updated = updated_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_result_bcd_display.sv
// ---------------------------------------------------------------------------
// Bench for result_bcd_display. Two instances share the clock and stimulus:
// one blanks leading zeros and one shows all six digits. The expected display
// is computed from the decimal digits of the input using division and modulo.
// ---------------------------------------------------------------------------
module tb_result_bcd_display;

  localparam int         IN_W    = 24;
  localparam int         LATENCY = IN_W + 2;
  localparam logic [6:0] BLANK   = 7'b1111111;
  localparam logic [6:0] DASH    = 7'b0111111;
  localparam logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000
  };
  localparam logic [41:0] RESET_DISP = {BLANK, BLANK, BLANK, BLANK, BLANK, 7'b1000000};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [IN_W-1:0] value = '0;

  logic [6:0] h0, h1, h2, h3, h4, h5;
  logic [6:0] n0, n1, n2, n3, n4, n5;
  logic       busy, upd, ovf;
  logic       nb_busy, nb_upd, nb_ovf;

  int n_vec = 0;
  int n_err = 0;
  logic [IN_W-1:0] cur_value = '0;

  always #5 clk = ~clk;

  result_bcd_display #(.IN_W(IN_W), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value),
    .hled0(h0), .hled1(h1), .hled2(h2), .hled3(h3), .hled4(h4), .hled5(h5),
    .busy(busy), .updated(upd), .ovf(ovf)
  );

  result_bcd_display #(.IN_W(IN_W), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .value(value),
    .hled0(n0), .hled1(n1), .hled2(n2), .hled3(n3), .hled4(n4), .hled5(n5),
    .busy(nb_busy), .updated(nb_upd), .ovf(nb_ovf)
  );

  // Expected six-digit display, digit i at bits [7*i +: 7].
  function automatic logic [41:0] model_disp(input int unsigned v, input bit blank);
    logic [41:0] r;
    int unsigned p;
    int unsigned d;
    r = '0;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      d = (v / p) % 10;
      if (v > 999999)                   r[7*i +: 7] = DASH;
      else if (blank && i > 0 && v < p) r[7*i +: 7] = BLANK;
      else                              r[7*i +: 7] = SEG[d];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the updated pulse and counts edges, starting at the next edge.
  // The wait is bounded. `stayed_busy` reports whether busy stayed high on
  // every cycle before the pulse.
  task automatic wait_updated(output int edges, output bit stayed_busy);
    edges = 0;
    stayed_busy = 1'b1;
    while (!upd && edges < 3 * LATENCY) begin
      if (!busy) stayed_busy = 1'b0;
      step();
      edges++;
    end
  endtask

  // Checks both display instances and the overflow flags against the model.
  task automatic check_display(input logic [IN_W-1:0] v, input string tag);
    logic [41:0] exp_b, exp_n, got_b, got_n;
    exp_b = model_disp(int'(v), 1'b1);
    exp_n = model_disp(int'(v), 1'b0);
    got_b = {h5, h4, h3, h2, h1, h0};
    got_n = {n5, n4, n3, n2, n1, n0};
    n_vec++;
    if (got_b !== exp_b) begin
      n_err++;
      $display("FAIL %s disp v=%0d: got %h expected %h", tag, v, got_b, exp_b);
    end
    n_vec++;
    if (got_n !== exp_n) begin
      n_err++;
      $display("FAIL %s disp_noblank v=%0d: got %h expected %h", tag, v, got_n, exp_n);
    end
    n_vec++;
    if ({ovf, nb_ovf} !== {2{(int'(v) > 999999)}}) begin
      n_err++;
      $display("FAIL %s ovf v=%0d: got %b%b expected %b", tag, v, ovf, nb_ovf, int'(v) > 999999);
    end
  endtask

  // A full conversion from IDLE: checks latency, busy, the pulse width and
  // the display.
  task automatic run_conversion(input logic [IN_W-1:0] v, input string tag);
    int edges;
    bit stayed;
    value = v;
    cur_value = v;
    step();
    n_vec++;
    if ({busy, nb_busy, upd} !== 3'b110) begin
      n_err++;
      $display("FAIL %s start: got busy=%b%b upd=%b expected 110", tag, busy, nb_busy, upd);
    end
    wait_updated(edges, stayed);
    edges++;
    n_vec++;
    if (edges != LATENCY || !stayed || nb_upd !== 1'b1) begin
      n_err++;
      $display("FAIL %s latency: got %0d edges busy_held=%b nb_upd=%b expected %0d 1 1",
               tag, edges, stayed, nb_upd, LATENCY);
    end
    check_display(v, tag);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_at_latch: got %b expected 0", tag, busy);
    end
    step();
    n_vec++;
    if ({upd, nb_upd, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL %s pulse_end: got upd=%b%b busy=%b expected 000", tag, upd, nb_upd, busy);
    end
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b1;
    value = '0;
    step();
    step();
    rst = 1'b0;
    step();
    n_vec++;
    if ({h5, h4, h3, h2, h1, h0} !== RESET_DISP || {n5, n4, n3, n2, n1, n0} !== RESET_DISP) begin
      n_err++;
      $display("FAIL reset disp: got %h / %h expected %h",
               {h5, h4, h3, h2, h1, h0}, {n5, n4, n3, n2, n1, n0}, RESET_DISP);
    end
    n_vec++;
    if ({busy, upd, ovf} !== 3'b000) begin
      n_err++;
      $display("FAIL reset flags: got busy=%b upd=%b ovf=%b expected 000", busy, upd, ovf);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (upd || busy) seen = 1'b1;
      step();
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL reset idle: got activity=1 expected 0");
    end
  endtask

  task automatic test_values();
    run_conversion(24'd7, "value7");
    run_conversion(24'd123456, "value123456");
  endtask

  task automatic test_overflow();
    run_conversion(24'd1000000, "ovf1000000");
    run_conversion(24'd999999, "max999999");
    run_conversion(24'hFFFFFF, "ovf_allones");
    run_conversion(24'd0, "zero");
  endtask

  task automatic test_back_to_back();
    int edges;
    bit stayed;
    value = 24'd5;
    step();
    step();
    step();
    step();
    value = 24'd42;
    cur_value = 24'd42;
    wait_updated(edges, stayed);
    edges += 4;
    n_vec++;
    if (edges != LATENCY || !stayed) begin
      n_err++;
      $display("FAIL b2b first latency: got %0d busy_held=%b expected %0d 1", edges, stayed, LATENCY);
    end
    check_display(24'd5, "b2b_first");
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b idle_gap: got busy=%b expected 0", busy);
    end
    step();
    n_vec++;
    if ({busy, upd} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b recapture: got busy=%b upd=%b expected 10", busy, upd);
    end
    wait_updated(edges, stayed);
    edges++;
    n_vec++;
    if (edges != LATENCY || !stayed) begin
      n_err++;
      $display("FAIL b2b second latency: got %0d busy_held=%b expected %0d 1", edges, stayed, LATENCY);
    end
    check_display(24'd42, "b2b_second");
    step();
  endtask

  task automatic test_no_blank();
    run_conversion(24'd100, "noblank100");
  endtask

  task automatic test_random();
    logic [IN_W-1:0] v;
    for (int k = 0; k < 20; k++) begin
      do begin
        case ($urandom_range(0, 3))
          0:       v = IN_W'($urandom_range(0, 99));
          1:       v = IN_W'($urandom_range(0, 999999));
          2:       v = IN_W'($urandom);
          default: v = IN_W'($urandom_range(999990, 1000009));
        endcase
      end while (v == cur_value);
      run_conversion(v, $sformatf("random%0d", k));
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    if (cur_value == 24'd55) run_conversion(24'd56, "pre_reset");
    value = 24'd55;
    step();
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    n_vec++;
    if ({h5, h4, h3, h2, h1, h0} !== RESET_DISP || {busy, upd, ovf} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_mid: got disp=%h busy=%b upd=%b ovf=%b expected %h 000",
               {h5, h4, h3, h2, h1, h0}, busy, upd, ovf, RESET_DISP);
    end
    value = '0;
    cur_value = '0;
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (upd || nb_upd || busy) seen = 1'b1;
    end
    n_vec++;
    if (seen || {h5, h4, h3, h2, h1, h0} !== RESET_DISP) begin
      n_err++;
      $display("FAIL reset_mid after: got activity=%b disp=%h expected 0 %h",
               seen, {h5, h4, h3, h2, h1, h0}, RESET_DISP);
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_overflow();
    test_back_to_back();
    test_no_blank();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
